// File: rtl/hwpe_stream_package.sv
// Shared types and helpers for the hwpe_stream packet multiplexer.
package hwpe_stream_package;

  typedef enum logic {
    MUX_IDLE  = 1'b0,
    MUX_ROUTE = 1'b1
  } hwpe_stream_mux_state_t;

  // Index width for an n-way selection, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream carrying data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_skid_slice.sv
// Two-entry stream register; push ready depends only on occupancy, never on pop ready.
module hwpe_stream_skid_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PAYLOAD_W  = DATA_WIDTH + STRB_WIDTH;

  logic [PAYLOAD_W-1:0] mem_q [2];
  logic [PAYLOAD_W-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 push_ready;
  logic                 push_hs;
  logic                 pop_hs;

  assign push_ready = (cnt_q != 2'd2);
  assign push_hs    = push_i.valid && push_ready;
  assign pop_hs     = (cnt_q != 2'd0) && pop_o.ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + 2'(push_hs) - 2'(pop_hs);
    if (push_hs) begin
      mem_d[wr_ptr_q] = {push_i.strb, push_i.data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_hs) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Clear drops whatever is buffered.
    if (clear_i) begin
      mem_d[0] = '0;
      mem_d[1] = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign push_i.ready              = push_ready;
  assign pop_o.valid               = (cnt_q != 2'd0);
  assign {pop_o.strb, pop_o.data}  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hwpe_stream_mux_packet.sv
// N:1 stream mux whose selection is accepted only at packet boundaries and held for len beats.
module hwpe_stream_mux_packet
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_IN_STREAMS     = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned LEN_WIDTH         = 16,
  parameter int unsigned REGISTERED_OUTPUT = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic [$clog2(NB_IN_STREAMS)-1:0] sel_i,
  input  logic [LEN_WIDTH-1:0]             len_i,
  input  logic                             sel_valid_i,
  output logic                             sel_ready_o,
  output logic                             err_o,
  hwpe_stream_intf_stream.sink             push_i [NB_IN_STREAMS-1:0],
  hwpe_stream_intf_stream.source           pop_o
);
  localparam int unsigned SEL_WIDTH  = sel_width(NB_IN_STREAMS);
  localparam int unsigned NB_SEL     = 2 ** SEL_WIDTH;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  hwpe_stream_mux_state_t state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                  push_valid [NB_SEL];
  logic [DATA_WIDTH-1:0] push_data  [NB_SEL];
  logic [STRB_WIDTH-1:0] push_strb  [NB_SEL];

  logic                  route;
  logic                  in_range;
  logic                  mux_valid;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [STRB_WIDTH-1:0] mux_strb;
  logic                  mux_ready;
  logic                  push_hs;
  logic                  last_beat;

  // Flatten the interface array so it can be indexed by sel_q; unused slots read as idle.
  for (genvar k = 0; k < NB_SEL; k++) begin : g_in
    if (k < NB_IN_STREAMS) begin : g_real
      assign push_valid[k]   = push_i[k].valid;
      assign push_data[k]    = push_i[k].data;
      assign push_strb[k]    = push_i[k].strb;
      assign push_i[k].ready = route && (sel_q == SEL_WIDTH'(k)) && mux_ready;
    end else begin : g_pad
      assign push_valid[k] = 1'b0;
      assign push_data[k]  = '0;
      assign push_strb[k]  = '0;
    end
  end

  if (NB_SEL == NB_IN_STREAMS) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (sel_i < SEL_WIDTH'(NB_IN_STREAMS));
  end

  assign route       = (state_q == MUX_ROUTE);
  assign mux_valid   = route && push_valid[sel_q];
  assign mux_data    = route ? push_data[sel_q] : '0;
  assign mux_strb    = route ? push_strb[sel_q] : '0;
  assign push_hs     = mux_valid && mux_ready;
  assign last_beat   = push_hs && (len_q != '0) && (cnt_q == len_q - LEN_WIDTH'(1));
  assign sel_ready_o = !route || last_beat;
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (push_hs) begin
      cnt_d = cnt_q + LEN_WIDTH'(1);
    end
    if (last_beat) begin
      state_d = MUX_IDLE;
    end
    // A request arriving on the last beat chains straight into the next packet.
    if (sel_valid_i && sel_ready_o) begin
      if (in_range) begin
        state_d = MUX_ROUTE;
        sel_d   = sel_i;
        len_d   = len_i;
        cnt_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (clear_i) begin
      state_d = MUX_IDLE;
      sel_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MUX_IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  if (REGISTERED_OUTPUT != 0) begin : g_reg_out
    hwpe_stream_intf_stream #(.DATA_WIDTH(DATA_WIDTH)) mux_s ();

    assign mux_s.valid = mux_valid;
    assign mux_s.data  = mux_data;
    assign mux_s.strb  = mux_strb;
    assign mux_ready   = mux_s.ready;

    hwpe_stream_skid_slice #(
      .DATA_WIDTH (DATA_WIDTH)
    ) i_slice (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (mux_s),
      .pop_o   (pop_o)
    );
  end else begin : g_comb_out
    assign pop_o.valid = mux_valid;
    assign pop_o.data  = mux_data;
    assign pop_o.strb  = mux_strb;
    assign mux_ready   = pop_o.ready;
  end

endmodule

// File: tb/tb_hwpe_stream_mux_packet.sv
// Bench for hwpe_stream_mux_packet: directed scenarios plus random packets against a packet-level model.
module tb_hwpe_stream_mux_packet;
  localparam int unsigned NB  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned SW  = $clog2(NB);
  localparam int unsigned STW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [SW-1:0] sel;
  logic [LW-1:0] len;
  logic          sel_valid;
  logic          sel_ready;
  logic          err;

  logic src_valid [NB];
  int   src_idx   [NB];
  logic push_rdy  [NB];
  logic pop_ready_tb;

  int checks = 0;
  int errors = 0;

  // Packet-level model: which input owns the output, beats left, expected output beats.
  bit          active;
  int          act_sel;
  int          remaining;
  logic [63:0] expq [$];
  int          alloc [NB];
  bit          err_exp;
  bit          take [NB];
  bit          sel_taken;
  int          cyc;
  int          first_hs [NB];
  int          last_hs  [NB];
  bit          rand_mode;
  int          reqs_left;
  bit          b2b;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  function automatic logic [31:0] word(input int k, input int i);
    return (32'(k) << 24) | (32'h0000_00A0 + 32'(i));
  endfunction

  function automatic logic [STW-1:0] strbf(input int k);
    return STW'(k + 1);
  endfunction

  function automatic logic [63:0] payload(input int k, input int i);
    return {28'h0, strbf(k), word(k, i)};
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_src
    assign push_if[g].valid = src_valid[g];
    assign push_if[g].data  = word(g, src_idx[g]);
    assign push_if[g].strb  = strbf(g);
    assign push_rdy[g]      = push_if[g].ready;
  end
  assign pop_if.ready = pop_ready_tb;

  hwpe_stream_mux_packet #(
    .NB_IN_STREAMS     (NB),
    .DATA_WIDTH        (DW),
    .LEN_WIDTH         (LW),
    .REGISTERED_OUTPUT (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .sel_i       (sel),
    .len_i       (len),
    .sel_valid_i (sel_valid),
    .sel_ready_o (sel_ready),
    .err_o       (err),
    .push_i      (push_if),
    .pop_o       (pop_if)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    active    = 1'b0;
    remaining = 0;
    err_exp   = 1'b0;
    expq.delete();
    for (int k = 0; k < NB; k++) alloc[k] = src_idx[k] + int'(take[k]);
  endtask

  task automatic check_reset_values();
    check("rst_sel_ready", 64'(sel_ready), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    check("rst_pop_valid", 64'(pop_if.valid), 64'(0));
    check("rst_pop_data", 64'(pop_if.data), 64'(0));
    check("rst_pop_strb", 64'(pop_if.strb), 64'(0));
    for (int k = 0; k < NB; k++) check("rst_push_ready", 64'(push_rdy[k]), 64'(0));
  endtask

  // Observe one cycle away from the clock edge and advance the model.
  task automatic sample();
    bit exp_sr;
    @(negedge clk);
    cyc++;
    exp_sr = !active || (remaining == 1 && src_valid[act_sel] && push_rdy[act_sel]);
    check("sel_ready", 64'(sel_ready), 64'(exp_sr));
    if (err_exp || err) check("err_pulse", 64'(err), 64'(err_exp));
    err_exp = 1'b0;
    for (int k = 0; k < NB; k++) begin
      take[k] = src_valid[k] && push_rdy[k];
      if (take[k]) begin
        check("push_route", 64'(active ? act_sel : 99), 64'(k));
        if (active && k == act_sel) begin
          last_hs[k] = cyc;
          if (first_hs[k] < 0) first_hs[k] = cyc;
          if (remaining < 0) begin
            expq.push_back(payload(k, alloc[k]));
            alloc[k]++;
          end else begin
            remaining--;
            if (remaining == 0) active = 1'b0;
          end
        end
      end
    end
    if (pop_if.valid && pop_ready_tb) begin
      if (expq.size() == 0) check("pop_valid_unexpected", 64'(pop_if.valid), 64'(0));
      else check("pop_beat", {28'h0, pop_if.strb, pop_if.data}, expq.pop_front());
    end
    sel_taken = sel_valid && sel_ready && !clear;
    if (sel_taken) begin
      if (int'(sel) < NB) begin
        active  = 1'b1;
        act_sel = int'(sel);
        if (len == '0) begin
          remaining = -1;
        end else begin
          remaining = int'(len);
          for (int i = 0; i < int'(len); i++) begin
            expq.push_back(payload(act_sel, alloc[act_sel]));
            alloc[act_sel]++;
          end
        end
      end else begin
        err_exp = 1'b1;
      end
    end
    if (clear) model_flush();
  endtask

  task automatic drive();
    bit took;
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) begin
      took = take[k];
      if (took) src_idx[k]++;
      take[k] = 1'b0;
      if (rand_mode && (!src_valid[k] || took)) src_valid[k] = ($urandom_range(0, 3) != 0);
    end
    if (sel_taken) sel_valid = 1'b0;
    sel_taken = 1'b0;
    if (rand_mode) begin
      pop_ready_tb = ($urandom_range(0, 3) != 0);
      if (!sel_valid && reqs_left > 0 && $urandom_range(0, 2) == 0) begin
        sel       = SW'($urandom_range(0, 7));
        len       = LW'($urandom_range(1, 6));
        sel_valid = 1'b1;
        reqs_left--;
      end
    end
  endtask

  task automatic cycle();
    sample();
    drive();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (active || expq.size() != 0 || sel_valid); i++) cycle();
    check("drain_pending", 64'(expq.size()) + 64'(active) + 64'(sel_valid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; sel_valid = 1'b0; sel = '0; len = '0;
    pop_ready_tb = 1'b0; rand_mode = 1'b0; reqs_left = 0; cyc = 0; b2b = 1'b0;
    for (int k = 0; k < NB; k++) begin
      src_valid[k] = 1'b0; src_idx[k] = 0; take[k] = 1'b0;
      first_hs[k] = -1; last_hs[k] = -1;
    end
    sel_taken = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Packet of 3 from input 2; the 4th word must stay unconsumed.
    pop_ready_tb = 1'b1;
    src_valid[2] = 1'b1;
    sel = SW'(2); len = LW'(3); sel_valid = 1'b1;
    drain(20);
    repeat (3) cycle();
    check("a3_held_idx", 64'(src_idx[2]), 64'(3));
    check("a3_held_ready", 64'(push_rdy[2]), 64'(0));
    check("idle_pop_valid", 64'(pop_if.valid), 64'(0));

    // Back-to-back: next request waits for and is taken on the last beat.
    for (int k = 0; k < NB; k++) first_hs[k] = -1;
    src_valid[0] = 1'b1;
    sel = SW'(2); len = LW'(3); sel_valid = 1'b1;
    b2b = 1'b0;
    for (int i = 0; i < 40 && !(b2b && !active && expq.size() == 0 && !sel_valid); i++) begin
      cycle();
      if (!sel_valid && !b2b) begin
        sel = SW'(0); len = LW'(2); sel_valid = 1'b1; b2b = 1'b1;
      end
    end
    check("b2b_no_bubble", 64'(first_hs[0]), 64'(last_hs[2] + 1));
    check("b2b_in2_ready", 64'(push_rdy[2]), 64'(0));
    check("b2b_in0_beats", 64'(src_idx[0]), 64'(2));
    src_valid[0] = 1'b0; src_valid[2] = 1'b0;

    // Out-of-range selection.
    sel = SW'(5); len = LW'(2); sel_valid = 1'b1;
    cycle();
    check("err_high", 64'(err), 64'(1));
    check("err_req_consumed", 64'(sel_valid), 64'(0));
    cycle();
    check("err_low", 64'(err), 64'(0));
    check("err_pop_valid", 64'(pop_if.valid), 64'(0));
    check("err_sel_ready", 64'(sel_ready), 64'(1));

    // Sticky packet across a counter wrap, left only through clear.
    src_valid[1] = 1'b1;
    sel = SW'(1); len = LW'(0); sel_valid = 1'b1;
    repeat (70002) cycle();
    check("sticky_sel_ready", 64'(sel_ready), 64'(0));
    check("sticky_in1_ready", 64'(push_rdy[1]), 64'(1));
    check("sticky_beats", 64'(src_idx[1]), 64'(70001));
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("clear_sel_ready", 64'(sel_ready), 64'(1));
    check("clear_pop_valid", 64'(pop_if.valid), 64'(0));
    check("clear_in1_ready", 64'(push_rdy[1]), 64'(0));
    src_valid[1] = 1'b0;

    // Backpressure: slice fills with 2 beats, then stalls the input.
    pop_ready_tb = 1'b0;
    src_valid[3] = 1'b1;
    sel = SW'(3); len = LW'(8); sel_valid = 1'b1;
    repeat (6) cycle();
    check("bp_buffered", 64'(src_idx[3]), 64'(2));
    check("bp_in3_ready", 64'(push_rdy[3]), 64'(0));
    check("bp_pop_valid", 64'(pop_if.valid), 64'(1));
    check("bp_pop_head", 64'(pop_if.data), 64'(word(3, 0)));
    pop_ready_tb = 1'b1;
    drain(40);
    check("bp_consumed", 64'(src_idx[3]), 64'(8));
    src_valid[3] = 1'b0;

    // Asynchronous reset mid-packet with one beat buffered.
    pop_ready_tb = 1'b0;
    src_valid[4] = 1'b1;
    sel = SW'(4); len = LW'(5); sel_valid = 1'b1;
    cycle();
    cycle();
    src_valid[4] = 1'b0;
    check("pre_rst_pop_valid", 64'(pop_if.valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_flush();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random packets, including out-of-range selections and chained requests.
    rand_mode = 1'b1;
    reqs_left = 60;
    for (int i = 0; i < 4000 && reqs_left > 0; i++) cycle();
    rand_mode = 1'b0;
    pop_ready_tb = 1'b1;
    for (int k = 0; k < NB; k++) src_valid[k] = 1'b1;
    drain(300);
    for (int k = 0; k < NB; k++) src_valid[k] = 1'b0;
    repeat (3) cycle();
    check("final_pop_valid", 64'(pop_if.valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
